// File: rtl/pwm_note_sequencer_pkg.sv
// Shared definitions for the note sequencer: FSM encodings, note-table entry
// layout and small field-extraction helpers.
package pwm_note_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PLAY    = 3'd2,
    ST_GAP     = 3'd3,
    ST_ADVANCE = 3'd4
  } state_t;

  localparam int TABLE_DEPTH = 16;
  localparam int IDX_W       = 4;
  localparam int ENTRY_W     = 16;
  localparam int DIV_W       = 12;
  localparam int LEN_W       = 4;

  localparam int DIV_MSB = 15;
  localparam int DIV_LSB = 4;
  localparam int LEN_MSB = 3;
  localparam int LEN_LSB = 0;

  function automatic logic [DIV_W-1:0] entry_div(input logic [ENTRY_W-1:0] e);
    return e[DIV_MSB:DIV_LSB];
  endfunction

  function automatic logic [LEN_W-1:0] entry_len(input logic [ENTRY_W-1:0] e);
    return e[LEN_MSB:LEN_LSB];
  endfunction

endpackage

// File: rtl/pwm_note_sequencer_if.sv
// Note-table write port shared between the register/IO logic and the sequencer.
interface pwm_note_sequencer_if;
  import pwm_note_sequencer_pkg::*;

  logic               wr_en;
  logic [IDX_W-1:0]   wr_addr;
  logic [ENTRY_W-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);

endinterface

// File: rtl/pwm_note_sequencer_tick_gen.sv
// Tempo tick generator: counts 0..tempo and pulses tick on the last count.
// Clearing holds the counter at zero so the first tick of a note comes a full
// tick period after the note starts.
module seq_tick_gen #(
  parameter int TEMPO_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic [TEMPO_W-1:0] tempo,
  output logic               tick
);

  logic [TEMPO_W-1:0] tick_cnt;
  logic               at_end;

  // Greater-or-equal so a tempo lowered below the running count wraps at once
  // instead of running the counter all the way round.
  assign at_end = (tick_cnt >= tempo);
  assign tick   = at_end & ~clear;

  // Free-running tick counter with wrap at tempo
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (clear || at_end) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TEMPO_W'(1);
    end
  end

endmodule

// File: rtl/pwm_note_sequencer.sv
// Melody sequencer driving the divider and run control of the sine PWM tone
// generator from a 16-entry {divider, len} note table.
module pwm_note_sequencer
  import pwm_note_sequencer_pkg::*;
#(
  parameter int GAP_TICKS = 1,
  parameter int TEMPO_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       stop,
  input  logic                       loop_en,
  input  logic [TEMPO_W-1:0]         tempo,
  pwm_note_sequencer_if.slave        wr,
  output logic [DIV_W-1:0]           divider,
  output logic                       tone_rst_n,
  output logic                       busy,
  output logic [IDX_W-1:0]           note_idx,
  output logic                       done
);

  localparam int GAP_W = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx_nxt;
  logic [DIV_W-1:0]   div_nxt;
  logic               tone_nxt;
  logic               busy_nxt;
  logic               done_nxt;
  logic [LEN_W-1:0]   rem, rem_nxt;
  logic [GAP_W-1:0]   gap_rem, gap_nxt;

  logic [ENTRY_W-1:0] note_table [TABLE_DEPTH];
  logic [ENTRY_W-1:0] entry;
  logic [DIV_W-1:0]   cur_div;
  logic [LEN_W-1:0]   cur_len;
  logic               tick;
  logic               tick_clear;

  assign entry   = note_table[note_idx];
  assign cur_div = entry_div(entry);
  assign cur_len = entry_len(entry);

  // Counter held at zero during LOAD so every note starts on a fresh tick
  assign tick_clear = (state == ST_LOAD);

  seq_tick_gen #(.TEMPO_W(TEMPO_W)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (tick_clear),
    .tempo (tempo),
    .tick  (tick)
  );

  // Note table storage; contents survive reset and are loaded by software
  always_ff @(posedge clk) begin
    if (wr.wr_en) begin
      note_table[wr.wr_addr] <= wr.wr_data;
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_nxt = state;
    idx_nxt   = note_idx;
    div_nxt   = divider;
    tone_nxt  = tone_rst_n;
    done_nxt  = 1'b0;
    rem_nxt   = rem;
    gap_nxt   = gap_rem;

    case (state)
      ST_IDLE: begin
        tone_nxt = 1'b0;
        if (start) begin
          state_nxt = ST_LOAD;
          idx_nxt   = '0;
        end
      end

      ST_LOAD: begin
        if (cur_len == '0) begin
          // End marker: loop back unless already at entry 0, which would spin
          if (loop_en && (note_idx != '0)) begin
            idx_nxt = '0;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          div_nxt   = cur_div;
          rem_nxt   = cur_len;
          tone_nxt  = (cur_div != '0);
          state_nxt = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (tick) begin
          rem_nxt = rem - LEN_W'(1);
          if (rem == LEN_W'(1)) begin
            tone_nxt = 1'b0;
            if (GAP_TICKS > 0) begin
              state_nxt = ST_GAP;
              gap_nxt   = GAP_W'(GAP_TICKS);
            end else begin
              state_nxt = ST_ADVANCE;
            end
          end
        end
      end

      ST_GAP: begin
        if (tick) begin
          gap_nxt = gap_rem - GAP_W'(1);
          if (gap_rem == GAP_W'(1)) begin
            state_nxt = ST_ADVANCE;
          end
        end
      end

      ST_ADVANCE: begin
        if (note_idx == IDX_W'(TABLE_DEPTH - 1)) begin
          if (loop_en) begin
            idx_nxt   = '0;
            state_nxt = ST_LOAD;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          idx_nxt   = note_idx + IDX_W'(1);
          state_nxt = ST_LOAD;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        tone_nxt  = 1'b0;
      end
    endcase

    // Abort wins over everything; divider is left at its last value
    if (stop) begin
      state_nxt = ST_IDLE;
      tone_nxt  = 1'b0;
      done_nxt  = 1'b0;
    end

    busy_nxt = (state_nxt != ST_IDLE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      note_idx   <= '0;
      divider    <= '0;
      tone_rst_n <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      rem        <= '0;
      gap_rem    <= '0;
    end else begin
      state      <= state_nxt;
      note_idx   <= idx_nxt;
      divider    <= div_nxt;
      tone_rst_n <= tone_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      rem        <= rem_nxt;
      gap_rem    <= gap_nxt;
    end
  end

endmodule
